tile_field: RTL and testbench

Downstream consumer of the 16-bit LFSR pattern generator in the falling-tiles game. On each scroll step it decodes the current pattern into a new top row, scrolls a ROWS×LANES playfield down by one row, and checks player key presses against the bottom row. It keeps the score and drives `lost`, which feeds back into the generator's `lost` input to freeze the pattern sequence.

---
 rtl/tiles_pkg.sv | 11 +
 rtl/tile_row_decode.sv | 24 ++
 rtl/tile_field.sv | 112 +++++++++++
 tb/tb_tile_field.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/tiles_pkg.sv
// Shared types and constants for the falling-tiles playfield logic.
package tiles_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } tile_state_t;

    localparam int PATTERN_W = 16;
    localparam int VALID_BIT = 15;
endpackage

// File: rtl/tile_row_decode.sv
// Combinational decode of a generator pattern into a one-hot (or empty) new row.
module tile_row_decode
    import tiles_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [PATTERN_W-1:0] pattern,
    output logic [LANES-1:0]     row
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0] lane_sel;
    logic          unused_bits;

    assign lane_sel    = pattern[LW-1:0];
    assign unused_bits = ^pattern[VALID_BIT-1:LW];

    always_comb begin
        row = '0;
        for (int l = 0; l < LANES; l++) begin
            row[l] = pattern[VALID_BIT] && (lane_sel == LW'(l));
        end
    end
endmodule

// File: rtl/tile_field.sv
// Playfield scroller, key checker and saturating scorer for the falling-tiles game.
module tile_field
    import tiles_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int LANES   = 4,
    parameter int SCORE_W = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  step,
    input  logic [PATTERN_W-1:0]  pattern,
    input  logic [LANES-1:0]      key,
    input  logic                  start,
    output logic [ROWS*LANES-1:0] field,
    output logic [SCORE_W-1:0]    score,
    output logic                  lost,
    output logic                  playing
);
    localparam int FW = ROWS * LANES;

    tile_state_t        state_q, state_d;
    logic [FW-1:0]      field_q, field_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic [LANES-1:0] new_row;
    logic [LANES-1:0] bottom, hit, miss, bottom_clr;

    function automatic logic [SCORE_W:0] popcount(input logic [LANES-1:0] v);
        logic [SCORE_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt = cnt + {{SCORE_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // The sum never reaches 2^(SCORE_W+1), so the carry bit alone flags overflow.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   inc);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + inc;
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    tile_row_decode #(.LANES(LANES)) u_decode (
        .pattern (pattern),
        .row     (new_row)
    );

    assign bottom     = field_q[(ROWS-1)*LANES +: LANES];
    assign hit        = key & bottom;
    assign miss       = key & ~bottom;
    assign bottom_clr = bottom & ~hit;

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                field_d = '0;
                score_d = '0;
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if (miss != '0) begin
                    state_d = LOST;
                end else begin
                    score_d = sat_add(score_q, popcount(hit));
                    field_d[(ROWS-1)*LANES +: LANES] = bottom_clr;
                    if (step) begin
                        if (bottom_clr != '0) begin
                            state_d = LOST;
                        end else begin
                            field_d = {field_q[FW-LANES-1:0], new_row};
                        end
                    end
                end
            end
            LOST: begin
                if (start) begin
                    state_d = PLAY;
                    field_d = '0;
                    score_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                field_d = '0;
                score_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            field_q <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            score_q <= score_d;
        end
    end

    assign field   = field_q;
    assign score   = score_q;
    assign lost    = (state_q == LOST);
    assign playing = (state_q == PLAY);
endmodule

// File: tb/tb_tile_field.sv
// Directed self-checking bench for tile_field at ROWS=8, LANES=4, SCORE_W=10.
module tb_tile_field;
    logic        clock;
    logic        reset;
    logic        step;
    logic [15:0] pattern;
    logic [3:0]  key;
    logic        start;
    logic [31:0] field;
    logic [9:0]  score;
    logic        lost;
    logic        playing;

    int n_checks = 0;
    int n_errors = 0;

    tile_field #(.ROWS(8), .LANES(4), .SCORE_W(10)) dut (
        .clock   (clock),
        .reset   (reset),
        .step    (step),
        .pattern (pattern),
        .key     (key),
        .start   (start),
        .field   (field),
        .score   (score),
        .lost    (lost),
        .playing (playing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] pat, input logic [3:0] k,
                         input logic sr);
        step    = st;
        pattern = pat;
        key     = k;
        start   = sr;
        @(posedge clock);
        #1;
        step    = 1'b0;
        pattern = 16'h0000;
        key     = 4'b0000;
        start   = 1'b0;
    endtask

    task automatic state_is(input string tag, input logic [31:0] f, input logic [9:0] s,
                            input logic l, input logic p);
        check_eq({tag, ".field"}, field, f);
        check_eq({tag, ".score"}, {22'd0, score}, {22'd0, s});
        check_eq({tag, ".lost"}, {31'd0, lost}, {31'd0, l});
        check_eq({tag, ".playing"}, {31'd0, playing}, {31'd0, p});
    endtask

    initial begin
        reset = 1'b0;
        step = 1'b0; pattern = 16'h0; key = 4'b0; start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        state_is("reset", 32'h0, 10'd0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 16'h0, 4'b0, 1'b0);
        state_is("idle", 32'h0, 10'd0, 1'b0, 1'b0);

        drive(1'b0, 16'h0, 4'b0, 1'b1);
        state_is("start", 32'h0, 10'd0, 1'b0, 1'b1);

        drive(1'b1, 16'h8002, 4'b0, 1'b0);
        check_eq("decode.row0", field, 32'h0000_0004);
        repeat (7) drive(1'b1, 16'h0000, 4'b0, 1'b0);
        state_is("scroll8", 32'h4000_0000, 10'd0, 1'b0, 1'b1);

        drive(1'b0, 16'h0, 4'b0100, 1'b0);
        state_is("hit", 32'h0, 10'd1, 1'b0, 1'b1);
        drive(1'b1, 16'h0000, 4'b0, 1'b0);
        state_is("hit.step", 32'h0, 10'd1, 1'b0, 1'b1);

        drive(1'b1, 16'h8003, 4'b0, 1'b0);
        repeat (7) drive(1'b1, 16'h0000, 4'b0, 1'b0);
        check_eq("lane3.bottom", field, 32'h8000_0000);
        drive(1'b1, 16'h8000, 4'b1000, 1'b0);
        state_is("key_step", 32'h0000_0001, 10'd2, 1'b0, 1'b1);

        repeat (7) drive(1'b1, 16'h0000, 4'b0, 1'b0);
        check_eq("lane0.bottom", field, 32'h1000_0000);
        drive(1'b1, 16'h8000, 4'b0011, 1'b0);
        state_is("wrongkey", 32'h1000_0000, 10'd2, 1'b1, 1'b0);
        drive(1'b1, 16'h8001, 4'b0001, 1'b0);
        state_is("lost.ignore", 32'h1000_0000, 10'd2, 1'b1, 1'b0);

        drive(1'b0, 16'h0, 4'b0, 1'b1);
        state_is("restart", 32'h0, 10'd0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 4'b0, 1'b1);
        state_is("start.inplay", 32'h0, 10'd0, 1'b0, 1'b1);

        drive(1'b1, 16'h8002, 4'b0, 1'b0);
        repeat (7) drive(1'b1, 16'h0000, 4'b0, 1'b0);
        drive(1'b1, 16'h8001, 4'b0, 1'b0);
        state_is("falloff", 32'h4000_0000, 10'd0, 1'b1, 1'b0);
        drive(1'b1, 16'h8001, 4'b0, 1'b0);
        state_is("falloff.frozen", 32'h4000_0000, 10'd0, 1'b1, 1'b0);

        drive(1'b1, 16'h8001, 4'b0100, 1'b1);
        state_is("start.step", 32'h0, 10'd0, 1'b0, 1'b1);

        repeat (8) drive(1'b1, 16'h8000, 4'b0, 1'b0);
        check_eq("sat.fill", field, 32'h1111_1111);
        repeat (1023) drive(1'b1, 16'h8000, 4'b0001, 1'b0);
        state_is("sat.1023", 32'h1111_1111, 10'd1023, 1'b0, 1'b1);
        drive(1'b1, 16'h8000, 4'b0001, 1'b0);
        state_is("sat.hold", 32'h1111_1111, 10'd1023, 1'b0, 1'b1);

        drive(1'b1, 16'h8000, 4'b0, 1'b0);
        state_is("sat.lost", 32'h1111_1111, 10'd1023, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 4'b0, 1'b1);
        state_is("sat.restart", 32'h0, 10'd0, 1'b0, 1'b1);

        drive(1'b1, 16'h8003, 4'b0, 1'b0);
        check_eq("pre_async.field", field, 32'h0000_0008);
        @(negedge clock);
        reset = 1'b0;
        #1;
        state_is("async_reset", 32'h0, 10'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b0, 16'h0, 4'b0, 1'b0);
        state_is("post_reset", 32'h0, 10'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
